regfile_wb_arbiter: RTL

- Shares the single register-file write port (reg_write / write_addr / write_data) between two writeback requesters: A = ALU result path, B = load-data path.
- Keeps a 32-entry pending-write scoreboard so decode can stall on operands whose producer has not yet written back.
- Sits between the execute/memory stages and the register file.
- Write port is driven from registered outputs, one cycle after acceptance.

---
 rtl/regfile_wb_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single register-file write port, with a pending-write scoreboard.
// Define REGFILE_WB_FWD_EN to add write-cycle forwarding outputs (fwdN_valid/fwdN_data).
//
// state  | meaning
// PRIO_A | A wins contention; B's consecutive denials are counted in r_wait_cnt
// PRIO_B | B starved MAX_WAIT cycles; B wins, A only when B idle
module regfile_wb_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  input  logic              reserve_valid,
  input  logic [ADDR_W-1:0] reserve_addr,
  input  logic [ADDR_W-1:0] read_addr1,
  input  logic [ADDR_W-1:0] read_addr2,
  output logic              busy1,
  output logic              busy2,
  output logic              reg_write,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data
`ifdef REGFILE_WB_FWD_EN
  ,
  output logic              fwd1_valid,
  output logic              fwd2_valid,
  output logic [DATA_W-1:0] fwd1_data,
  output logic [DATA_W-1:0] fwd2_data
`endif
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

  typedef enum logic {PRIO_A, PRIO_B} state_t;

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_wait_cnt, w_wait_nxt;
  logic [NREG-1:0]   r_pend, w_pend_nxt;
  logic              r_reg_write;
  logic [ADDR_W-1:0] r_write_addr;
  logic [DATA_W-1:0] r_write_data;

  logic              w_a_ready, w_b_ready, w_acc;
  logic [ADDR_W-1:0] w_acc_addr;
  logic [DATA_W-1:0] w_acc_data;
  logic              w_inflight1, w_inflight2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= PRIO_A;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  always_comb begin
    w_a_ready   = 1'b0;
    w_b_ready   = 1'b0;
    w_state_nxt = r_state;
    w_wait_nxt  = '0;
    case (r_state)
      PRIO_A: begin
        w_a_ready = a_valid;
        w_b_ready = b_valid && !a_valid;
        // Switch on the edge where the count reaches MAX_WAIT, so B wins the next cycle
        if (b_valid && !w_b_ready) begin
          if ((r_wait_cnt + 4'd1) >= LP_MAX_WAIT) begin
            w_wait_nxt  = LP_MAX_WAIT;
            w_state_nxt = PRIO_B;
          end else begin
            w_wait_nxt = r_wait_cnt + 4'd1;
          end
        end
      end
      PRIO_B: begin
        w_b_ready   = b_valid;
        w_a_ready   = a_valid && !b_valid;
        w_state_nxt = PRIO_A;
      end
      default: w_state_nxt = PRIO_A;
    endcase
  end

  assign a_ready    = w_a_ready;
  assign b_ready    = w_b_ready;
  assign w_acc      = w_a_ready || w_b_ready;
  assign w_acc_addr = w_a_ready ? a_addr : b_addr;
  assign w_acc_data = w_a_ready ? a_data : b_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg_write  <= 1'b0;
      r_write_addr <= '0;
      r_write_data <= '0;
    end else begin
      r_reg_write <= w_acc && (w_acc_addr != '0);
      if (w_acc) begin
        r_write_addr <= w_acc_addr;
        r_write_data <= w_acc_data;
      end
    end
  end

  // Set after clear: a same-cycle reservation is a newer producer and must stay pending
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_acc) w_pend_nxt[w_acc_addr] = 1'b0;
    if (reserve_valid) w_pend_nxt[reserve_addr] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pend <= '0;
    else        r_pend <= w_pend_nxt;
  end

  assign reg_write  = r_reg_write;
  assign write_addr = r_write_addr;
  assign write_data = r_write_data;

  assign w_inflight1 = r_reg_write && (r_write_addr == read_addr1);
  assign w_inflight2 = r_reg_write && (r_write_addr == read_addr2);

`ifdef REGFILE_WB_FWD_EN
  assign fwd1_valid = w_inflight1 && (read_addr1 != '0);
  assign fwd2_valid = w_inflight2 && (read_addr2 != '0);
  assign fwd1_data  = r_write_data;
  assign fwd2_data  = r_write_data;
  assign busy1 = r_pend[read_addr1] && !w_inflight1 && (read_addr1 != '0);
  assign busy2 = r_pend[read_addr2] && !w_inflight2 && (read_addr2 != '0);
`else
  // The regfile read only reflects a write the cycle after reg_write
  assign busy1 = (r_pend[read_addr1] || w_inflight1) && (read_addr1 != '0);
  assign busy2 = (r_pend[read_addr2] || w_inflight2) && (read_addr2 != '0);
`endif

endmodule
